// File: rtl/cpu_bus_datapath_pkg.sv
// Shared constants for the phase-1 bus datapath: word width, ALU one-hot
// bit positions and the bus-source codes produced by the priority encoder.
package cpu_pkg;

  localparam int WORD    = 32;
  localparam int NUM_GPR = 16;
  localparam int NUM_SRC = 24;
  localparam int NUM_ALU = 12;

  // ALUControl bit positions
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_MUL = 2;
  localparam int ALU_DIV = 3;
  localparam int ALU_AND = 4;
  localparam int ALU_OR  = 5;
  localparam int ALU_SHR = 6;
  localparam int ALU_SHL = 7;
  localparam int ALU_ROR = 8;
  localparam int ALU_ROL = 9;
  localparam int ALU_NEG = 10;
  localparam int ALU_NOT = 11;

  // Bus source codes; R0..R15 occupy codes 0..15
  localparam logic [4:0] SRC_HI     = 5'd16;
  localparam logic [4:0] SRC_LO     = 5'd17;
  localparam logic [4:0] SRC_ZHIGH  = 5'd18;
  localparam logic [4:0] SRC_ZLOW   = 5'd19;
  localparam logic [4:0] SRC_PC     = 5'd20;
  localparam logic [4:0] SRC_MDR    = 5'd21;
  localparam logic [4:0] SRC_INPORT = 5'd22;
  localparam logic [4:0] SRC_C      = 5'd23;

endpackage

// File: rtl/cpu_bus_datapath_alu.sv
// Combinational ALU: result = A op B, A is the Y register, B is the bus.
// Lowest set control bit selects the operation; no bit set gives 0.
module alu
  import cpu_pkg::*;
(
  input  logic [WORD-1:0]    a,
  input  logic [WORD-1:0]    b,
  input  logic [NUM_ALU-1:0] ctrl,
  output logic [2*WORD-1:0]  result
);

  logic [4:0]        sh;
  logic [2*WORD-1:0] prod;
  logic [WORD-1:0]   abs_a, abs_b, uq, ur, quo, rem;

  assign sh = b[4:0];

  // Signed product from sign-extended operands; the low 64 bits are exact
  assign prod = {{WORD{a[WORD-1]}}, a} * {{WORD{b[WORD-1]}}, b};

  // Signed divide built on magnitudes so INT_MIN / -1 stays well defined;
  // quotient truncates toward zero, remainder follows the dividend's sign
  always_comb begin
    abs_a = a[WORD-1] ? -a : a;
    abs_b = b[WORD-1] ? -b : b;
    uq    = '0;
    ur    = '0;
    if (b != '0) begin
      uq = abs_a / abs_b;
      ur = abs_a % abs_b;
    end
    quo = (a[WORD-1] ^ b[WORD-1]) ? -uq : uq;
    rem = a[WORD-1] ? -ur : ur;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end
  end

  // Priority operation select, lowest control bit first
  always_comb begin
    result = '0;
    if      (ctrl[ALU_ADD]) result = {32'h0, a + b};
    else if (ctrl[ALU_SUB]) result = {32'h0, a - b};
    else if (ctrl[ALU_MUL]) result = prod;
    else if (ctrl[ALU_DIV]) result = {rem, quo};
    else if (ctrl[ALU_AND]) result = {32'h0, a & b};
    else if (ctrl[ALU_OR])  result = {32'h0, a | b};
    else if (ctrl[ALU_SHR]) result = {32'h0, a >> sh};
    else if (ctrl[ALU_SHL]) result = {32'h0, a << sh};
    else if (ctrl[ALU_ROR]) result = {32'h0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
    else if (ctrl[ALU_ROL]) result = {32'h0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
    else if (ctrl[ALU_NEG]) result = {32'h0, -b};
    else if (ctrl[ALU_NOT]) result = {32'h0, ~b};
  end

endmodule

// File: rtl/cpu_bus_datapath.sv
// Phase-1 single-bus datapath: register file, HI/LO/Y/Z/MDR, priority bus
// encoder + mux, and the ALU. PC, InPort and C are placeholders reading 0.
module cpu_bus_datapath
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  output logic [31:0] BusMuxOut,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        Zin, Yin, LOin, HIin, MDRin,
  output logic [31:0] R0MuxIn, R1MuxIn, R2MuxIn, R3MuxIn,
  output logic [31:0] R4MuxIn, R5MuxIn, R6MuxIn, R7MuxIn,
  output logic [31:0] R8MuxIn, R9MuxIn, R10MuxIn, R11MuxIn,
  output logic [31:0] R12MuxIn, R13MuxIn, R14MuxIn, R15MuxIn,
  output logic [31:0] HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn,
  output logic [31:0] PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn,
  input  logic [11:0] ALUControl,
  input  logic [31:0] Mdatain,
  input  logic        MDRRead,
  output logic [31:0] Yout
);

  logic [NUM_GPR-1:0][WORD-1:0] gpr;
  logic [NUM_GPR-1:0]           gpr_in;
  logic [WORD-1:0]              hi, lo, y, mdr, bus;
  logic [WORD-1:0]              pc, inport, cval;
  logic [2*WORD-1:0]            z, alu_res;
  logic [NUM_SRC-1:0]           src_sel;
  logic [4:0]                   src_code;
  logic                         src_hit;

  assign src_sel = {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                    R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign gpr_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // No load path exists for these yet
  assign pc     = '0;
  assign inport = '0;
  assign cval   = '0;

  // Priority encoder: scan high to low so the lowest asserted code wins
  always_comb begin
    src_code = '0;
    src_hit  = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_sel[i]) begin
        src_code = 5'(i);
        src_hit  = 1'b1;
      end
    end
  end

  // Bus mux driven by the encoded source; idle bus reads 0
  always_comb begin
    bus = '0;
    if (src_hit) begin
      if (!src_code[4]) bus = gpr[src_code[3:0]];
      else begin
        case (src_code)
          SRC_HI:     bus = hi;
          SRC_LO:     bus = lo;
          SRC_ZHIGH:  bus = z[63:32];
          SRC_ZLOW:   bus = z[31:0];
          SRC_PC:     bus = pc;
          SRC_MDR:    bus = mdr;
          SRC_INPORT: bus = inport;
          SRC_C:      bus = cval;
          default:    bus = '0;
        endcase
      end
    end
  end

  alu u_alu (
    .a      (y),
    .b      (bus),
    .ctrl   (ALUControl),
    .result (alu_res)
  );

  // Register loads; clr wins over every enable
  always_ff @(posedge clk) begin
    if (clr) begin
      gpr <= '0;
      hi  <= '0;
      lo  <= '0;
      y   <= '0;
      mdr <= '0;
      z   <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++)
        if (gpr_in[i]) gpr[i] <= bus;
      if (HIin)  hi  <= bus;
      if (LOin)  lo  <= bus;
      if (Yin)   y   <= bus;
      if (MDRin) mdr <= MDRRead ? Mdatain : bus;
      if (Zin)   z   <= alu_res;
    end
  end

  assign BusMuxOut   = bus;
  assign R0MuxIn     = gpr[0];
  assign R1MuxIn     = gpr[1];
  assign R2MuxIn     = gpr[2];
  assign R3MuxIn     = gpr[3];
  assign R4MuxIn     = gpr[4];
  assign R5MuxIn     = gpr[5];
  assign R6MuxIn     = gpr[6];
  assign R7MuxIn     = gpr[7];
  assign R8MuxIn     = gpr[8];
  assign R9MuxIn     = gpr[9];
  assign R10MuxIn    = gpr[10];
  assign R11MuxIn    = gpr[11];
  assign R12MuxIn    = gpr[12];
  assign R13MuxIn    = gpr[13];
  assign R14MuxIn    = gpr[14];
  assign R15MuxIn    = gpr[15];
  assign HIMuxIn     = hi;
  assign LOMuxIn     = lo;
  assign ZhighMuxIn  = z[63:32];
  assign ZlowMuxIn   = z[31:0];
  assign PCMuxIn     = pc;
  assign MDRMuxIn    = mdr;
  assign InPortMuxIn = inport;
  assign CMuxIn      = cval;
  assign Yout        = y;

endmodule

// File: tb/tb_cpu_bus_datapath.sv
// Self-checking bench for cpu_bus_datapath: directed test-plan sequences,
// a table of ALU vectors, and randomized cycles against a behavioural model.
module tb_cpu_bus_datapath;

  logic               clk;
  logic               clr;
  logic [23:0]        osel;
  logic [15:0]        rin;
  logic               Zin, Yin, LOin, HIin, MDRin, MDRRead;
  logic [11:0]        ALUControl;
  logic [31:0]        Mdatain;
  logic [31:0]        BusMuxOut, Yout;
  logic [15:0][31:0]  rmux;
  logic [31:0]        HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn;
  logic [31:0]        PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn;

  int n_cmp  = 0;
  int n_fail = 0;

  // behavioural model state
  logic [31:0] mr [16];
  logic [31:0] mhi, mlo, my, mmdr;
  logic [63:0] mz;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  cpu_bus_datapath dut (
    .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut),
    .R0out(osel[0]), .R1out(osel[1]), .R2out(osel[2]), .R3out(osel[3]),
    .R4out(osel[4]), .R5out(osel[5]), .R6out(osel[6]), .R7out(osel[7]),
    .R8out(osel[8]), .R9out(osel[9]), .R10out(osel[10]), .R11out(osel[11]),
    .R12out(osel[12]), .R13out(osel[13]), .R14out(osel[14]), .R15out(osel[15]),
    .HIout(osel[16]), .LOout(osel[17]), .Zhighout(osel[18]), .Zlowout(osel[19]),
    .PCout(osel[20]), .MDRout(osel[21]), .InPortout(osel[22]), .Cout(osel[23]),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .Zin(Zin), .Yin(Yin), .LOin(LOin), .HIin(HIin), .MDRin(MDRin),
    .R0MuxIn(rmux[0]), .R1MuxIn(rmux[1]), .R2MuxIn(rmux[2]), .R3MuxIn(rmux[3]),
    .R4MuxIn(rmux[4]), .R5MuxIn(rmux[5]), .R6MuxIn(rmux[6]), .R7MuxIn(rmux[7]),
    .R8MuxIn(rmux[8]), .R9MuxIn(rmux[9]), .R10MuxIn(rmux[10]), .R11MuxIn(rmux[11]),
    .R12MuxIn(rmux[12]), .R13MuxIn(rmux[13]), .R14MuxIn(rmux[14]), .R15MuxIn(rmux[15]),
    .HIMuxIn(HIMuxIn), .LOMuxIn(LOMuxIn), .ZhighMuxIn(ZhighMuxIn), .ZlowMuxIn(ZlowMuxIn),
    .PCMuxIn(PCMuxIn), .MDRMuxIn(MDRMuxIn), .InPortMuxIn(InPortMuxIn), .CMuxIn(CMuxIn),
    .ALUControl(ALUControl), .Mdatain(Mdatain), .MDRRead(MDRRead), .Yout(Yout)
  );

  typedef struct {
    string       nm;
    logic [31:0] y;
    logic [31:0] b;
    logic [11:0] ctl;
    logic [63:0] z;
  } alu_vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference ALU written straight from the operation rules using integer math
  function automatic logic [63:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [11:0] c);
    longint sa, sb, q, r, p;
    int k, n;
    logic [31:0] t;
    k = -1;
    for (int i = 11; i >= 0; i--) if (c[i]) k = i;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    t  = '0;
    case (k)
      0:  return {32'h0, a + b};
      1:  return {32'h0, a - b};
      2:  begin p = sa * sb; return p; end
      3:  begin
            if (sb == 0) return {a, 32'hFFFFFFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
          end
      4:  return {32'h0, a & b};
      5:  return {32'h0, a | b};
      6:  return {32'h0, a >> n};
      7:  return {32'h0, a << n};
      8:  begin for (int i = 0; i < 32; i++) t[i] = a[(i + n) % 32]; return {32'h0, t}; end
      9:  begin for (int i = 0; i < 32; i++) t[i] = a[(i - n + 32) % 32]; return {32'h0, t}; end
      10: return {32'h0, 32'h0 - b};
      11: return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_bus();
    logic [31:0] src [24];
    for (int i = 0; i < 16; i++) src[i] = mr[i];
    src[16] = mhi;  src[17] = mlo;  src[18] = mz[63:32]; src[19] = mz[31:0];
    src[20] = 32'h0; src[21] = mmdr; src[22] = 32'h0; src[23] = 32'h0;
    for (int i = 0; i < 24; i++) if (osel[i]) return src[i];
    return 32'h0;
  endfunction

  task automatic model_edge();
    logic [31:0] b;
    logic [63:0] res;
    b   = model_bus();
    res = ref_alu(my, b, ALUControl);
    if (clr) begin
      for (int i = 0; i < 16; i++) mr[i] = '0;
      mhi = '0; mlo = '0; my = '0; mmdr = '0; mz = '0;
    end else begin
      for (int i = 0; i < 16; i++) if (rin[i]) mr[i] = b;
      if (HIin)  mhi  = b;
      if (LOin)  mlo  = b;
      if (Yin)   my   = b;
      if (MDRin) mmdr = MDRRead ? Mdatain : b;
      if (Zin)   mz   = res;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), {32'h0, rmux[i]}, {32'h0, mr[i]});
    chk("HI", {32'h0, HIMuxIn}, {32'h0, mhi});
    chk("LO", {32'h0, LOMuxIn}, {32'h0, mlo});
    chk("Z", {ZhighMuxIn, ZlowMuxIn}, mz);
    chk("MDR", {32'h0, MDRMuxIn}, {32'h0, mmdr});
    chk("Y", {32'h0, Yout}, {32'h0, my});
    chk("PC/InPort/C", {PCMuxIn | InPortMuxIn | CMuxIn}, 64'h0);
  endtask

  // Check the bus, clock one edge, advance the model, check all registers
  task automatic tick();
    #1;
    chk("bus", {32'h0, BusMuxOut}, {32'h0, model_bus()});
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    clr = 0; osel = '0; rin = '0; Zin = 0; Yin = 0; LOin = 0; HIin = 0;
    MDRin = 0; MDRRead = 0; ALUControl = '0; Mdatain = '0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle(); Mdatain = v; MDRRead = 1; MDRin = 1; tick();
  endtask

  alu_vec_t vt[$];

  initial begin
    for (int i = 0; i < 16; i++) mr[i] = '0;
    mhi = '0; mlo = '0; my = '0; mmdr = '0; mz = '0;
    idle();
    clr = 1;
    tick();
    chk("reset Z", {ZhighMuxIn, ZlowMuxIn}, 64'h0);

    // Load 26 into R2 and 5 into R4 through MDR
    load_mdr(32'd26);
    idle(); osel[21] = 1; rin[2] = 1; tick();
    chk("R2=26", {32'h0, rmux[2]}, 64'd26);
    load_mdr(32'd5);
    idle(); osel[21] = 1; rin[4] = 1; tick();
    chk("R4=5", {32'h0, rmux[4]}, 64'd5);

    // 26 / 5 then move quotient to LO and remainder to HI
    idle(); osel[2] = 1; Yin = 1; tick();
    idle(); osel[4] = 1; ALUControl = 12'h008; Zin = 1; tick();
    chk("div zlow", {32'h0, ZlowMuxIn}, 64'd5);
    chk("div zhigh", {32'h0, ZhighMuxIn}, 64'd1);
    idle(); osel[19] = 1; LOin = 1; tick();
    chk("LO=5", {32'h0, LOMuxIn}, 64'd5);
    idle(); osel[18] = 1; HIin = 1; tick();
    chk("HI=1", {32'h0, HIMuxIn}, 64'd1);

    // Source is also load target: keeps its old value
    idle(); osel[2] = 1; rin[2] = 1; tick();
    chk("R2 self", {32'h0, rmux[2]}, 64'd26);

    // Encoder priority and idle bus
    load_mdr(32'h33);
    idle(); osel[21] = 1; rin[3] = 1; tick();
    load_mdr(32'h77);
    idle(); osel[3] = 1; osel[21] = 1; #1;
    chk("prio R3 over MDR", {32'h0, BusMuxOut}, 64'h33);
    idle(); #1;
    chk("idle bus", {32'h0, BusMuxOut}, 64'h0);

    // MDR loading from the bus when MDRRead is low
    idle(); osel[16] = 1; MDRin = 1; tick();
    chk("MDR from bus", {32'h0, MDRMuxIn}, 64'd1);

    // ALU vector table: Y via MDR, then B via MDR onto the bus
    vt.push_back(alu_vec_t'{"add wrap", 32'hFFFFFFFF, 32'h2,        12'h001, 64'h1});
    vt.push_back(alu_vec_t'{"sub",      32'h3,        32'h5,        12'h002, 64'h00000000_FFFFFFFE});
    vt.push_back(alu_vec_t'{"mul 2^32", 32'h00010000, 32'h00010000, 12'h004, 64'h00000001_00000000});
    vt.push_back(alu_vec_t'{"mul -3*7", 32'hFFFFFFFD, 32'h7,        12'h004, 64'hFFFFFFFF_FFFFFFEB});
    vt.push_back(alu_vec_t'{"mul min2", 32'h80000000, 32'h80000000, 12'h004, 64'h40000000_00000000});
    vt.push_back(alu_vec_t'{"div 26/5", 32'd26,       32'd5,        12'h008, 64'h00000001_00000005});
    vt.push_back(alu_vec_t'{"div -7/2", 32'hFFFFFFF9, 32'h2,        12'h008, 64'hFFFFFFFF_FFFFFFFD});
    vt.push_back(alu_vec_t'{"div 9/0",  32'd9,        32'd0,        12'h008, 64'h00000009_FFFFFFFF});
    vt.push_back(alu_vec_t'{"div 7/-2", 32'd7,        32'hFFFFFFFE, 12'h008, 64'h00000001_FFFFFFFD});
    vt.push_back(alu_vec_t'{"div min/-1", 32'h80000000, 32'hFFFFFFFF, 12'h008, 64'h00000000_80000000});
    vt.push_back(alu_vec_t'{"and",      32'hF0F0F0F0, 32'h0FF00FF0, 12'h010, 64'h00F000F0});
    vt.push_back(alu_vec_t'{"or",       32'hF0F0F0F0, 32'h0F0F0000, 12'h020, 64'hFFFFF0F0});
    vt.push_back(alu_vec_t'{"shr",      32'h80000000, 32'h4,        12'h040, 64'h08000000});
    vt.push_back(alu_vec_t'{"shr b4:0", 32'h80000000, 32'h21,       12'h040, 64'h40000000});
    vt.push_back(alu_vec_t'{"shl",      32'h1,        32'h1F,       12'h080, 64'h80000000});
    vt.push_back(alu_vec_t'{"ror",      32'h12345678, 32'h8,        12'h100, 64'h78123456});
    vt.push_back(alu_vec_t'{"rol",      32'h12345678, 32'h4,        12'h200, 64'h23456781});
    vt.push_back(alu_vec_t'{"neg",      32'h5,        32'h1,        12'h400, 64'hFFFFFFFF});
    vt.push_back(alu_vec_t'{"not",      32'h5,        32'h0000FFFF, 12'h800, 64'hFFFF0000});
    vt.push_back(alu_vec_t'{"multi add", 32'h2,       32'h3,        12'h011, 64'h5});
    vt.push_back(alu_vec_t'{"none",     32'h2,        32'h3,        12'h000, 64'h0});
    foreach (vt[i]) begin
      load_mdr(vt[i].y);
      idle(); osel[21] = 1; Yin = 1; tick();
      load_mdr(vt[i].b);
      idle(); osel[21] = 1; ALUControl = vt[i].ctl; Zin = 1; tick();
      chk(vt[i].nm, {ZhighMuxIn, ZlowMuxIn}, vt[i].z);
    end

    // Reset between Yin and Zin, with R5in and Zin asserted on the clr edge
    load_mdr(32'h1234);
    idle(); osel[21] = 1; Yin = 1; tick();
    idle(); clr = 1; osel[21] = 1; rin[5] = 1; Zin = 1; ALUControl = 12'h001; tick();
    chk("clr R5", {32'h0, rmux[5]}, 64'h0);
    chk("clr Z", {ZhighMuxIn, ZlowMuxIn}, 64'h0);
    chk("clr Y", {32'h0, Yout}, 64'h0);
    chk("clr MDR", {32'h0, MDRMuxIn}, 64'h0);
    chk("clr LO/HI", {LOMuxIn, HIMuxIn}, 64'h0);

    // Randomized cycles against the model
    for (int n = 0; n < 400; n++) begin
      int pick;
      idle();
      pick = int'($urandom_range(0, 99));
      if (pick < 75)      osel = 24'(1) << $urandom_range(0, 23);
      else if (pick < 85) osel = '0;
      else                osel = 24'($urandom);
      rin        = 16'($urandom & $urandom);
      Zin        = ($urandom_range(0, 2) == 0);
      Yin        = ($urandom_range(0, 2) == 0);
      LOin       = ($urandom_range(0, 3) == 0);
      HIin       = ($urandom_range(0, 3) == 0);
      MDRin      = ($urandom_range(0, 2) == 0);
      MDRRead    = $urandom_range(0, 1) == 1;
      Mdatain    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      ALUControl = ($urandom_range(0, 9) < 7) ? 12'(1) << $urandom_range(0, 11) : 12'($urandom);
      clr        = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_datapath.md
# cpu_bus_datapath

Phase-1 CPU datapath built around one shared 32-bit bus. It holds the general-purpose registers R0–R15, HI, LO, Y, the 64-bit Z, MDR, PC, InPort and C. A 24-source bus multiplexer with an encoder selects what drives the bus, and a one-hot controlled ALU computes `Z ← Y op Bus`. A control-unit testbench sequences it today; the control FSM replaces the testbench in a later phase.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous, active-high reset.
- BusMuxOut  out  32  current bus value.
- R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout  in  1 each  bus-source selects.
- R0in..R15in, Zin, Yin, LOin, HIin, MDRin  in  1 each  register load enables.
- R0MuxIn..R15MuxIn  out  32 each  register contents.
- HIMuxIn, LOMuxIn, ZhighMuxIn, ZlowMuxIn, PCMuxIn, MDRMuxIn, InPortMuxIn, CMuxIn  out  32 each  register contents.
- ALUControl  in  12  one-hot ALU operation select.
- Mdatain  in  32  memory data input.
- MDRRead  in  1  MDR input select: 1 = Mdatain, 0 = bus.
- Yout  out  32  Y register contents.

## Operation

**Bus source encoding**
- Codes: R0..R15 = 0..15, HI = 16, LO = 17, Zhigh = 18, Zlow = 19, PC = 20, MDR = 21, InPort = 22, C = 23.
- If several selects are asserted, the lowest code wins.
- If no select is asserted, the bus is 0.

**Registers**
- On a rising edge with its enable high:
  - R0–R15, HI, LO and Y load the bus value.
  - MDR loads `MDRRead ? Mdatain : BusMuxOut`.
  - Z loads the ALU result. Zhigh is Z[63:32] and Zlow is Z[31:0].
- PC, InPort and C have no load enables in this phase and read 0.

**ALU** (combinational; A = Y, B = bus)
- Bit 0 ADD, bit 1 SUB (A−B), bit 2 MUL (signed 64-bit product), bit 3 DIV, bit 4 AND, bit 5 OR, bit 6 SHR (logical, by B[4:0]), bit 7 SHL, bit 8 ROR, bit 9 ROL, bit 10 NEG (−B), bit 11 NOT (~B).
- DIV is signed, truncates toward zero, and gives Z[31:0] = quotient, Z[63:32] = remainder. The remainder takes the sign of the dividend.
- Divide by zero gives quotient 32'hFFFFFFFF and remainder A.
- All non-MUL/DIV operations zero-fill Z[63:32]. ADD and SUB wrap modulo 2^32.
- If several ALUControl bits are set, the lowest set bit wins. If none is set, the result is 0.

## Timing
- Bus, encoder and ALU are purely combinational, so a bus change is visible the same cycle.
- Every register has 1-cycle latency: new value after the rising edge that samples its enable.
- clr=1 at a rising edge zeros every register, including Z (64 bits), and all `*MuxIn` outputs and Yout. clr overrides any enable in the same cycle.
- Reset in the middle of a multi-step sequence (for example between Yin and Zin) leaves the datapath fully zeroed; there is no partial state.
- One bus source per cycle is the normal protocol. Multiple sources are legal and resolved by priority; they never cause X.
- A register that is both the bus source and a load target in the same cycle reloads its own old value.

## Structure
- Shared package `cpu_pkg` holds:
  - the ALU one-hot bit-index constants,
  - the 5-bit encoder source codes,
  - the width constant 32.
- Sub-modules:
  - `alu` is the natural combinational sub-module (32-bit A and B in, 12-bit control in, 64-bit result out).
  - A 32-to-5 priority encoder may be inlined.
  - A generic `reg32` may be inlined or reused.
- The simulation clock generator `clock_gen` is bench-only and not synthesizable. Its single output is clk with a 20 ns period, starting at 0.

## Test plan
- Load via MDR: Mdatain = 26, MDRRead = 1, MDRin for one edge, then MDRout + R2in. Required: R2MuxIn = 26. Repeat with 5 into R4.
- DIV: R2out + Yin, then R4out + ALUControl = 12'h008 + Zin. Required: ZlowMuxIn = 5 and ZhighMuxIn = 1. Then Zlowout + LOin gives LO = 5, and Zhighout + HIin gives HI = 1.
- MUL signed: Y = 0x00010000, B = 0x00010000. Required: Zhigh = 1, Zlow = 0. Also Y = −3, B = 7 gives Z = 64-bit −21.
- Division edge cases: −7 / 2 gives quotient −3, remainder −1. 9 / 0 gives quotient FFFFFFFF, remainder 9.
- Encoder: R3out and MDRout both asserted gives the bus value R3. No select asserted gives bus 0.
- Reset: assert clr for one edge while R5in and Zin are high with nonzero data. Required: all outputs 0 after that edge.
